// File: rtl/multicore_pkg.sv
// Shared state encoding and helpers for the multicore miner controller.
package multicore_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t NEWTARGET = 3'd1;
    localparam state_t NEWMSG    = 3'd2;
    localparam state_t START     = 3'd3;
    localparam state_t WAIT      = 3'd4;
    localparam state_t EVAL      = 3'd5;
    localparam state_t FOUND     = 3'd6;
    localparam state_t EIDLE     = 3'd7;

    // Index of the lowest set bit; callers zero-extend narrower masks to 16 bits.
    function automatic logic [3:0] lowest_set(input logic [15:0] mask);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/multicore_controller_nonce_counter.sv
// Nonce base register: synchronous clear, fixed-step advance, carry-out of the next step.
module nonce_counter #(
    parameter int unsigned W    = 32,
    parameter int unsigned STEP = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         advance_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);

    logic [W-1:0] value_q, value_d;
    logic [W:0]   sum;

    assign sum     = {1'b0, value_q} + (W+1)'(STEP);
    assign carry_o = sum[W];
    assign value_o = value_q;

    // An advance that would wrap is dropped so the base stays at the last legal value.
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (advance_i && !carry_o) begin
            value_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) value_q <= '0;
        else       value_q <= value_d;
    end

endmodule

// File: rtl/multicore_controller.sv
// Dispatches one message/target to NUM_CORES SHA cores and steps the nonce base until a find.
// Optional watchdog on the core wait enabled by defining MULTICORE_WATCHDOG_EN.
module multicore_controller
    import multicore_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned NONCE_W     = 32,
    parameter int unsigned CORE_IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  newTarget,
    input  logic                  newMsg,
    input  logic [NUM_CORES-1:0]  coreComplete,
    input  logic [NUM_CORES-1:0]  coreValid,
    output logic                  loadTarget,
    output logic                  loadMsg,
    output logic                  coreStart,
    output logic [NONCE_W-1:0]    nonceBase,
    output logic                  found,
    output logic [CORE_IDX_W-1:0] foundCore,
    output logic [NONCE_W-1:0]    foundNonce,
    output logic                  error
`ifdef MULTICORE_WATCHDOG_EN
    ,
    output logic                  wdogTrip
`endif
);

    state_t                state_q, state_d;
    logic [NUM_CORES-1:0]  done_q, done_d, valid_q, valid_d;
    logic [CORE_IDX_W-1:0] core_q, core_d;
    logic [NONCE_W-1:0]    fnonce_q, fnonce_d;
    logic                  base_clear, base_advance, base_carry;
    logic                  all_done, wdog_expire;
    logic [15:0]           valid_ext;
    logic [3:0]            lowest;
    logic [CORE_IDX_W-1:0] lowest_idx;

    nonce_counter #(
        .W    (NONCE_W),
        .STEP (NUM_CORES)
    ) u_nonce (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (base_clear),
        .advance_i (base_advance),
        .value_o   (nonceBase),
        .carry_o   (base_carry)
    );

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_CORES-1:0] = valid_q;
    end

    assign lowest     = lowest_set(valid_ext);
    assign lowest_idx = lowest[CORE_IDX_W-1:0];
    // Includes this cycle's completions so EVAL follows the last arrival directly.
    assign all_done   = &(done_q | coreComplete);

`ifdef MULTICORE_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        trip_q, trip_d;

    assign wdog_expire = (wdog_q == 32'(WDOG_CYCLES - 1));
    assign wdogTrip    = trip_q;

    always_comb begin
        wdog_d = wdog_q;
        trip_d = trip_q;
        if (state_q == START) wdog_d = '0;
        if (state_q == WAIT)  wdog_d = wdog_q + 32'd1;
        if (state_q == NEWMSG) trip_d = 1'b0;
        if (state_q == WAIT && !all_done && wdog_expire) trip_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            trip_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            trip_q <= trip_d;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        valid_d      = valid_q;
        core_d       = core_q;
        fnonce_d     = fnonce_q;
        base_clear   = 1'b0;
        base_advance = 1'b0;
        case (state_q)
            IDLE, EIDLE, FOUND: begin
                if (newTarget)   state_d = NEWTARGET;
                else if (newMsg) state_d = NEWMSG;
            end
            NEWTARGET: state_d = IDLE;
            NEWMSG: begin
                base_clear = 1'b1;
                done_d     = '0;
                valid_d    = '0;
                state_d    = START;
            end
            START: begin
                done_d  = '0;
                valid_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                done_d  = done_q | coreComplete;
                valid_d = valid_q | (coreComplete & coreValid);
                if (all_done)         state_d = EVAL;
                else if (wdog_expire) state_d = EIDLE;
            end
            EVAL: begin
                if (|valid_q) begin
                    core_d   = lowest_idx;
                    fnonce_d = nonceBase + NONCE_W'(lowest_idx);
                    state_d  = FOUND;
                end else if (base_carry) begin
                    state_d = EIDLE;
                end else begin
                    base_advance = 1'b1;
                    state_d      = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= '0;
            valid_q  <= '0;
            core_q   <= '0;
            fnonce_q <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            core_q   <= core_d;
            fnonce_q <= fnonce_d;
        end
    end

    assign loadTarget = (state_q == NEWTARGET);
    assign loadMsg    = (state_q == NEWMSG);
    assign coreStart  = (state_q == START);
    assign found      = (state_q == FOUND);
    assign error      = (state_q == EIDLE);
    assign foundCore  = core_q;
    assign foundNonce = fnonce_q;

endmodule

// File: tb/tb_multicore_controller.sv
// Scoreboard bench: instance A (32-bit nonce, 4 cores) and instance B (4-bit nonce) for overflow.
module tb_multicore_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // is_find=0: expected nonceBase at a coreStart; is_find=1: expected find result.
    typedef struct packed {
        logic        is_find;
        logic [1:0]  core;
        logic [31:0] val;
    } sb_t;

    sb_t a_q[$];
    sb_t b_q[$];

    // ---------------- instance A ----------------
    logic        a_nt, a_nm;
    logic [3:0]  a_cc, a_cv;
    logic        a_lt, a_lm, a_cs, a_found, a_err;
    logic [31:0] a_base, a_fn;
    logic [1:0]  a_fc;
`ifdef MULTICORE_WATCHDOG_EN
    logic        a_wdog;
`endif

    multicore_controller #(
        .NUM_CORES   (4),
        .NONCE_W     (32),
        .WDOG_CYCLES (8)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .newTarget    (a_nt),
        .newMsg       (a_nm),
        .coreComplete (a_cc),
        .coreValid    (a_cv),
        .loadTarget   (a_lt),
        .loadMsg      (a_lm),
        .coreStart    (a_cs),
        .nonceBase    (a_base),
        .found        (a_found),
        .foundCore    (a_fc),
        .foundNonce   (a_fn),
        .error        (a_err)
`ifdef MULTICORE_WATCHDOG_EN
        ,
        .wdogTrip     (a_wdog)
`endif
    );

    // ---------------- instance B ----------------
    logic       b_nt, b_nm;
    logic [3:0] b_cc, b_cv;
    logic       b_lt, b_lm, b_cs, b_found, b_err;
    logic [3:0] b_base, b_fn;
    logic [1:0] b_fc;
`ifdef MULTICORE_WATCHDOG_EN
    logic       b_wdog;
`endif

    multicore_controller #(
        .NUM_CORES (4),
        .NONCE_W   (4)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .newTarget    (b_nt),
        .newMsg       (b_nm),
        .coreComplete (b_cc),
        .coreValid    (b_cv),
        .loadTarget   (b_lt),
        .loadMsg      (b_lm),
        .coreStart    (b_cs),
        .nonceBase    (b_base),
        .found        (b_found),
        .foundCore    (b_fc),
        .foundNonce   (b_fn),
        .error        (b_err)
`ifdef MULTICORE_WATCHDOG_EN
        ,
        .wdogTrip     (b_wdog)
`endif
    );

    // ---------------- scoreboard monitors ----------------
    logic a_found_d;
    always @(negedge clk) begin
        if (!rst && a_cs) begin
            if (a_q.size() == 0) begin
                check("a_start_unexpected", 1, 0);
            end else begin
                check("a_start_kind", a_q[0].is_find, 0);
                check("a_start_base", a_base, a_q[0].val);
                void'(a_q.pop_front());
            end
        end
        if (!rst && a_found && !a_found_d) begin
            if (a_q.size() == 0) begin
                check("a_found_unexpected", 1, 0);
            end else begin
                check("a_find_kind", a_q[0].is_find, 1);
                check("a_find_core", a_fc, a_q[0].core);
                check("a_find_nonce", a_fn, a_q[0].val);
                void'(a_q.pop_front());
            end
        end
        a_found_d <= rst ? 1'b0 : a_found;
    end

    always @(negedge clk) begin
        if (!rst && b_cs) begin
            if (b_q.size() == 0) begin
                check("b_start_unexpected", 1, 0);
            end else begin
                check("b_start_base", b_base, b_q[0].val);
                void'(b_q.pop_front());
            end
        end
    end

    // ---------------- model helpers ----------------
    logic [31:0] a_model_base;

    function automatic logic [1:0] model_lowest(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) model_lowest = 2'(i);
        end
    endfunction

    task automatic push_a_base(input logic [31:0] b);
        sb_t t;
        t.is_find = 1'b0;
        t.core    = 2'd0;
        t.val     = b;
        a_q.push_back(t);
    endtask

    task automatic push_a_find(input logic [1:0] c, input logic [31:0] n);
        sb_t t;
        t.is_find = 1'b1;
        t.core    = c;
        t.val     = n;
        a_q.push_back(t);
    endtask

    task automatic push_b_base(input logic [31:0] b);
        sb_t t;
        t.is_find = 1'b0;
        t.core    = 2'd0;
        t.val     = b;
        b_q.push_back(t);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        a_nt = 0; a_nm = 0; a_cc = 0; a_cv = 0;
        b_nt = 0; b_nm = 0; b_cc = 0; b_cv = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic a_wait_start();
        for (int k = 0; k < 30 && !a_cs; k++) @(negedge clk);
        check("a_start_seen", a_cs, 1);
    endtask

    task automatic b_wait_start();
        for (int k = 0; k < 30 && !b_cs; k++) @(negedge clk);
        check("b_start_seen", b_cs, 1);
    endtask

    // Ends at the NEWMSG cycle with the expected base 0 queued.
    task automatic a_msg();
        @(negedge clk);
        a_nm = 1'b1;
        @(negedge clk);
        check("a_loadmsg", a_lm, 1);
        a_nm         = 1'b0;
        a_model_base = 32'd0;
        push_a_base(32'd0);
    endtask

    // One round with all cores completing in the first WAIT cycle; ends at EVAL.
    task automatic a_round(input logic [3:0] v);
        a_wait_start();
        @(negedge clk);
        a_cc = 4'hf;
        a_cv = v;
        @(negedge clk);
        a_cc = 4'h0;
        a_cv = 4'h0;
        if (v == 4'h0) begin
            a_model_base = a_model_base + 32'd4;
            push_a_base(a_model_base);
        end else begin
            push_a_find(model_lowest(v), a_model_base + 32'(model_lowest(v)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        a_nt = 0; a_nm = 0; a_cc = 0; a_cv = 0;
        b_nt = 0; b_nm = 0; b_cc = 0; b_cv = 0;
        repeat (2) @(negedge clk);
        check("rst_outs", {a_lt, a_lm, a_cs, a_found, a_err}, 5'b0);
        check("rst_base", a_base, 0);
        check("rst_fcore", a_fc, 0);
        check("rst_fnonce", a_fn, 0);
        rst = 1'b0;

        // newMsg -> loadMsg for one cycle, coreStart next with base 0
        a_msg();
        @(negedge clk);
        check("start_after_msg", a_cs, 1);
        check("loadmsg_one_cycle", a_lm, 0);

        // Two empty rounds then cores 1,2 valid at base 8
        a_round(4'h0);
        a_round(4'h0);
        a_round(4'b0110);
        @(negedge clk);
        check("found_flag", a_found, 1);
        check("found_core", a_fc, 1);
        check("found_nonce", a_fn, 9);
        @(negedge clk);
        check("found_hold", {a_found, a_fc}, {1'b1, 2'd1});
        check("found_nonce_hold", a_fn, 9);

        // Staggered completion; completions outside WAIT must be ignored
        a_cc = 4'hf;
        a_cv = 4'hf;
        a_nm = 1'b1;
        @(negedge clk);
        check("stag_loadmsg", a_lm, 1);
        check("found_clears", a_found, 0);
        a_nm         = 1'b0;
        a_model_base = 32'd0;
        push_a_base(32'd0);
        @(negedge clk);
        check("stag_start", a_cs, 1);
        for (int w = 1; w <= 7; w++) begin
            @(negedge clk);
            a_cc = 4'h0;
            a_cv = 4'h0;
            if (w == 1) a_cc = 4'b0101;
            if (w == 4) begin
                a_cc = 4'b1000;
                a_cv = 4'b1000;
            end
            if (w == 7) a_cc = 4'b0010;
            if (w == 6) check("stag_waiting", {a_cs, a_found, a_err}, 3'b0);
        end
        @(negedge clk);
        a_cc = 4'h0;
        push_a_find(2'd3, 32'd3);
        check("stag_eval_not_found", a_found, 0);
        @(negedge clk);
        check("stag_found", a_found, 1);
        check("stag_core", a_fc, 3);

        // newTarget in FOUND loads target and leaves FOUND
        a_nt = 1'b1;
        @(negedge clk);
        check("tgt_load", a_lt, 1);
        check("tgt_found_clear", a_found, 0);
        a_nt = 1'b0;
        @(negedge clk);
        check("tgt_one_cycle", {a_lt, a_lm, a_cs}, 3'b0);

        // newTarget and newMsg together: target first, message next IDLE cycle
        a_nt = 1'b1;
        a_nm = 1'b1;
        @(negedge clk);
        check("both_lt_lm", {a_lt, a_lm}, 2'b10);
        a_nt = 1'b0;
        @(negedge clk);
        check("both_idle", {a_lt, a_lm}, 2'b00);
        @(negedge clk);
        check("both_msg", a_lm, 1);
        a_nm         = 1'b0;
        a_model_base = 32'd0;
        push_a_base(32'd0);

        // Reset mid-WAIT aborts and clears the base
        a_round(4'h0);
        a_wait_start();
        @(negedge clk);
        a_cc = 4'b0001;
        check("mid_wait_base", a_base, 4);
        rst = 1'b1;
        #1;
        check("async_rst_base", a_base, 0);
        @(negedge clk);
        rst  = 1'b0;
        a_cc = 4'h0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {a_cs, a_found, a_err, a_lm}, 4'b0);

`ifdef MULTICORE_WATCHDOG_EN
        // Core 2 never completes: EIDLE after 8 WAIT cycles
        a_msg();
        a_wait_start();
        for (int w = 1; w <= 8; w++) begin
            @(negedge clk);
            a_cc = 4'b1011;
        end
        check("wdog_not_yet", a_err, 0);
        @(negedge clk);
        a_cc = 4'h0;
        check("wdog_error", a_err, 1);
        check("wdog_trip", a_wdog, 1);
        @(negedge clk);
        check("wdog_sticky", a_wdog, 1);
        a_msg();
        @(negedge clk);
        check("wdog_clear", {a_wdog, a_err}, 2'b00);
        do_reset();
`endif

        // Instance B: 4-bit nonce overflows after bases 0,4,8,12
        do_reset();
        @(negedge clk);
        b_nm = 1'b1;
        @(negedge clk);
        b_nm = 1'b0;
        for (int r = 0; r < 4; r++) push_b_base(32'(4 * r));
        for (int r = 0; r < 4; r++) begin
            b_wait_start();
            @(negedge clk);
            b_cc = 4'hf;
            @(negedge clk);
            b_cc = 4'h0;
        end
        @(negedge clk);
        check("ovf_error", b_err, 1);
        check("ovf_base", b_base, 12);
        @(negedge clk);
        check("ovf_hold", {b_err, b_cs, b_found}, 3'b100);
        b_nm = 1'b1;
        @(negedge clk);
        check("ovf_msg", {b_lm, b_err}, 2'b10);
        b_nm = 1'b0;
        push_b_base(32'd0);
        @(negedge clk);
        check("ovf_restart", b_cs, 1);
        check("ovf_base_clear", b_base, 0);

        repeat (2) @(negedge clk);
        check("a_sb_drain", 64'(a_q.size()), 0);
        check("b_sb_drain", 64'(b_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
